// File: rtl/sequencia_leds_pkg.sv
// Shared types and defaults for the LED sequence presenter: state codes, LED width, timing defaults.
package sequencia_leds_pkg;

   localparam int LED_WIDTH          = 4;
   localparam int N_ENDERECOS_PADRAO = 16;
   localparam int T_ACESO_PADRAO     = 1000;
   localparam int T_APAGADO_PADRAO   = 500;

   // Codes are also what the 7-segment debug display shows.
   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      PREPARA = 4'd1,
      ACESO   = 4'd2,
      APAGADO = 4'd3,
      PROXIMO = 4'd4,
      FIM     = 4'd5
   } estado_t;

   function automatic int largura_timer(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/sequencia_leds_if.sv
// Control/ROM-side bundle of the LED sequence presenter; SEQUENCIA_LEDS_PARAR_EN adds the parar abort line.
interface sequencia_leds_if #(
   parameter int AW = 4
);
   import sequencia_leds_pkg::*;

   logic                 mostrar;
   logic [AW-1:0]        limite;
   logic [LED_WIDTH-1:0] dado_memoria;
   logic [AW-1:0]        endereco;
   logic [LED_WIDTH-1:0] leds;
   logic                 ocupado;
   logic                 fim;
   logic [3:0]           db_estado;
`ifdef SEQUENCIA_LEDS_PARAR_EN
   logic                 parar;

   modport slave  (input  mostrar, limite, dado_memoria, parar,
                   output endereco, leds, ocupado, fim, db_estado);
   modport master (output mostrar, limite, dado_memoria, parar,
                   input  endereco, leds, ocupado, fim, db_estado);
`else
   modport slave  (input  mostrar, limite, dado_memoria,
                   output endereco, leds, ocupado, fim, db_estado);
   modport master (output mostrar, limite, dado_memoria,
                   input  endereco, leds, ocupado, fim, db_estado);
`endif

endinterface

// File: rtl/sequencia_leds_timer.sv
// Modulo-M down-counter: zera reloads M-1, conta decrements, fim flags the last counted cycle.
module sequencia_leds_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   input  logic [W-1:0] modulo,
   output logic         fim
);

   logic [W-1:0] cnt_q, cnt_d;

   assign fim = conta && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (zera)
         cnt_d = modulo - W'(1);
      else if (conta)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sequencia_leds.sv
// Plays ROM entries 0..limite on the LEDs (on-time then dark gap each); outputs decoded from registered state.
// Optional SEQUENCIA_LEDS_PARAR_EN adds a parar input that aborts presentation back to INICIAL without fim.
module sequencia_leds
   import sequencia_leds_pkg::*;
#(
   parameter int N_ENDERECOS = N_ENDERECOS_PADRAO,
   parameter int T_ACESO     = T_ACESO_PADRAO,
   parameter int T_APAGADO   = T_APAGADO_PADRAO
) (
   input  logic           clock,
   input  logic           reset,
   sequencia_leds_if.slave bus
);

   localparam int AW = $clog2(N_ENDERECOS);
   localparam int TW = largura_timer(T_ACESO, T_APAGADO);

   localparam logic [3:0] S_INICIAL = INICIAL;
   localparam logic [3:0] S_PREPARA = PREPARA;
   localparam logic [3:0] S_ACESO   = ACESO;
   localparam logic [3:0] S_APAGADO = APAGADO;
   localparam logic [3:0] S_PROXIMO = PROXIMO;
   localparam logic [3:0] S_FIM     = FIM;

   localparam logic [TW-1:0] MOD_ACESO   = TW'(T_ACESO);
   localparam logic [TW-1:0] MOD_APAGADO = TW'(T_APAGADO);

   logic [3:0]           estado_q, estado_d;
   logic [AW-1:0]        endereco_q, endereco_d;
   logic [AW-1:0]        limite_q, limite_d;
   logic [LED_WIDTH-1:0] dado_q, dado_d;

   logic          conta, zera, timer_fim, parar_ativo;
   logic [TW-1:0] modulo;

`ifdef SEQUENCIA_LEDS_PARAR_EN
   assign parar_ativo = bus.parar;
`else
   assign parar_ativo = 1'b0;
`endif

   // The timer is reloaded in every non-counting state and on each expiry, so
   // ACESO and APAGADO always start from a full period.
   assign conta  = (estado_q == S_ACESO) || (estado_q == S_APAGADO);
   assign zera   = !conta || timer_fim;
   assign modulo = (estado_q == S_ACESO) ? MOD_APAGADO : MOD_ACESO;

   sequencia_leds_timer #(.W(TW)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .conta  (conta),
      .modulo (modulo),
      .fim    (timer_fim)
   );

   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      dado_d     = dado_q;
      case (estado_q)
         S_INICIAL: begin
            endereco_d = '0;
            if (bus.mostrar && !parar_ativo) begin
               limite_d = bus.limite;
               estado_d = S_PREPARA;
            end
         end
         S_PREPARA: begin
            dado_d   = bus.dado_memoria;
            estado_d = S_ACESO;
         end
         S_ACESO: begin
            if (timer_fim)
               estado_d = S_APAGADO;
         end
         S_APAGADO: begin
            if (timer_fim) begin
               if (endereco_q == limite_q) begin
                  estado_d = S_FIM;
               end else begin
                  // Advance here so the ROM sees the new address during PROXIMO
                  // and its data is ready by the end of PREPARA.
                  endereco_d = endereco_q + AW'(1);
                  estado_d   = S_PROXIMO;
               end
            end
         end
         S_PROXIMO: estado_d = S_PREPARA;
         S_FIM: begin
            endereco_d = '0;
            estado_d   = S_INICIAL;
         end
         default: begin
            endereco_d = '0;
            estado_d   = S_INICIAL;
         end
      endcase
      if (parar_ativo && (estado_q != S_INICIAL)) begin
         endereco_d = '0;
         estado_d   = S_INICIAL;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= S_INICIAL;
         endereco_q <= '0;
         limite_q   <= '0;
         dado_q     <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         dado_q     <= dado_d;
      end
   end

   assign bus.endereco  = endereco_q;
   assign bus.leds      = (estado_q == S_ACESO) ? dado_q : '0;
   assign bus.ocupado   = (estado_q != S_INICIAL);
   assign bus.fim       = (estado_q == S_FIM);
   assign bus.db_estado = estado_q;

endmodule

// File: doc/sequencia_leds.md
# sequencia_leds

Sequence presenter for the button-memory game: on a start pulse it reads the stored sequence from the external 16x4 synchronous ROM, entries 0 through `limite`, and shows each entry on the LEDs for a fixed on-time followed by a fixed dark gap. It is the output side of the game. The existing datapath compares player button presses against memory; this block plays the same memory contents back to the player before each round. It sits between the game control unit (which issues `mostrar` and waits for `fim`) and the sequence ROM (whose read address it drives during presentation).

## Interface
- `N_ENDERECOS`, 16: number of ROM entries. Address width `AW = $clog2(N_ENDERECOS)`.
- `T_ACESO`, 1000: clock cycles each entry is lit (≥1).
- `T_APAGADO`, 500: clock cycles of dark gap after each entry (≥1).
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mostrar` in 1: start request, sampled only in INICIAL.
- `limite` in AW: index of last entry to show; captured at start.
- `dado_memoria` in 4: ROM read data, valid one cycle after `endereco`.
- `endereco` out AW: ROM read address.
- `leds` out 4: LED drive, one bit per button.
- `ocupado` out 1: high in every state except INICIAL.
- `fim` out 1: one-cycle pulse when presentation completes.
- `db_estado` out 4: current state encoding, for the 7-segment debug display.

## Operation
- States and `db_estado` codes:
  - INICIAL=0
  - PREPARA=1
  - ACESO=2
  - APAGADO=3
  - PROXIMO=4
  - FIM=5
  - Unused codes go to INICIAL.
- INICIAL: `endereco`=0, `leds`=0, timer cleared. `mostrar`=1 captures `limite` into `limite_r` and moves to PREPARA.
- PREPARA (1 cycle): `endereco` stable; ROM produces data. Moves to ACESO. On entry to ACESO, `dado_memoria` is registered into `dado_r`.
- ACESO: `leds`=`dado_r`. The timer counts `T_ACESO` cycles, then the FSM moves to APAGADO with the timer cleared.
- APAGADO: `leds`=0. After `T_APAGADO` cycles:
  - if `endereco`==`limite_r`, go to FIM;
  - otherwise go to PROXIMO.
- PROXIMO (1 cycle): `endereco` += 1, then go to PREPARA.
- FIM (1 cycle): `fim`=1, `endereco` reset to 0, then go to INICIAL.
- `mostrar` is ignored while `ocupado`=1. Changes to `limite` during presentation have no effect.
- `limite`=0 shows exactly one entry. `limite`=N_ENDERECOS-1 shows all entries. `endereco` never wraps.
- An entry value of 0 is shown as a dark ACESO period. Timing is unchanged.
- Asynchronous reset (`reset`=0) at any point:
  - state=INICIAL;
  - `endereco`, `leds`, `dado_r`, `limite_r` and the timer all 0;
  - `ocupado`=0, `fim`=0, `db_estado`=0.
  - No `fim` pulse is produced for the aborted sequence.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from `mostrar` to any output.
- Cycle 0 is the edge where `mostrar` is sampled high. PREPARA is at cycle 1. First `leds` valid at cycle 2.
- Per-entry period = 1 (PREPARA) + `T_ACESO` + `T_APAGADO` + 1 (PROXIMO or FIM).
- Total duration from `mostrar` to `fim` pulse = (`limite`+1)×(`T_ACESO`+`T_APAGADO`+2).
- `fim` is high for exactly one cycle. `ocupado` falls on the cycle after `fim`.
- A new `mostrar` is accepted on the first INICIAL cycle after FIM.

## Configuration
- `SEQUENCIA_LEDS_PARAR_EN` defined:
  - adds input port `parar` (1 bit);
  - `parar`=1 in any state other than INICIAL forces INICIAL on the next edge, with `leds`=0 and `endereco`=0;
  - no `fim` pulse is produced;
  - `parar` has priority over timer expiry;
  - `parar` has no effect in INICIAL, and a simultaneous `mostrar` is not accepted.
- Not defined: no `parar` port; presentation always runs to FIM.

## Structure
- Shared package `sequencia_leds_pkg` holds:
  - the state enum (4-bit encoding above);
  - the `LED_WIDTH`=4 constant;
  - the default timing constants.
- One sub-module, `sequencia_leds_timer`:
  - modulo-M down-counter with `zera` (clear) and `conta` (count) inputs and a `fim` output;
  - width `$clog2(max(T_ACESO,T_APAGADO)+1)`;
  - the top module reloads it on each ACESO and APAGADO entry.
- The FSM and the address counter live in the top module.

## Test plan
All scenarios use `T_ACESO`=4, `T_APAGADO`=2 and ROM contents {1,2,4,8,...}.
- Reset held low, then released → all outputs 0 and `db_estado`=0. `mostrar` pulse with `limite`=0 → `leds`=1 for 4 cycles, then 0 for 2 cycles; `fim` pulses 8 cycles after the start edge.
- `limite`=3 → `leds` shows 1, 2, 4, 8, each for 4 cycles with 0-gaps between; `fim` at cycle 32. Check `endereco` steps 0→3 and never exceeds 3.
- `mostrar` re-pulsed and `limite` changed to 1 mid-sequence → no restart; still 4 entries shown; a single `fim` pulse.
- `limite`=15 with ROM entries 0..15 → all 16 shown; `endereco` stops at 15; `fim` at cycle 128.
- Reset asserted during ACESO of entry 2 → `leds`=0 and `ocupado`=0 immediately (asynchronous); no `fim`; the next `mostrar` starts from entry 0.
- With `SEQUENCIA_LEDS_PARAR_EN` defined: `parar` pulsed during APAGADO of entry 1 → state INICIAL next cycle; no `fim`. A `parar` coinciding with timer expiry is still honoured.
